// File: rtl/ifm_stream_ctrl.sv
// Sequencer for one convolution unit: weight-window load, then IFM raster stream with window-valid strobes.
// Optional `IFM_STREAM_HOLD_EN` adds a hold input that stalls read issue in LOAD_W/STREAM.
module ifm_stream_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 18,
  parameter int IFM_SIZE         = 32,
  parameter int KERNAL_SIZE      = 5,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE),
  parameter int FIFO_SIZE        = (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef IFM_STREAM_HOLD_EN
  input  logic                        hold,
`endif
  input  logic                        start,
  input  logic [ADDRESS_BITS-1:0]     wm_base_address,
  input  logic [DATA_WIDTH-1:0]       ifm_data_in,
  output logic                        ifm_enable_read,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address,
  output logic                        wm_enable_read,
  output logic [ADDRESS_BITS-1:0]     wm_address,
  output logic                        wm_fifo_enable,
  output logic [DATA_WIDTH-1:0]       unit_data_in,
  output logic                        fifo_enable,
  output logic                        conv_enable,
  output logic                        busy,
  output logic                        done
);

  localparam int AIW = ADDRESS_SIZE_IFM;
  localparam int WCW = $clog2(KERNAL_SIZE*KERNAL_SIZE+1);
  localparam int PW  = AIW + 1;
  localparam logic [WCW-1:0] W_LAST   = WCW'(KERNAL_SIZE*KERNAL_SIZE-1);
  localparam logic [AIW-1:0] IFM_LAST = AIW'(IFM_SIZE*IFM_SIZE-1);
  localparam logic [AIW-1:0] LAST_COL = AIW'(IFM_SIZE-1);
  localparam logic [AIW-1:0] K_EDGE   = AIW'(KERNAL_SIZE-1);
  localparam logic [PW-1:0]  P_MIN    = PW'(FIFO_SIZE-1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

  state_e                  state_q;
  logic                    wm_rd_q, ifm_rd_q;
  logic                    wm_fifo_en_q, fifo_en_q, conv_q;
  logic                    busy_q, done_q, drain_q;
  logic [ADDRESS_BITS-1:0] wm_addr_q;
  logic [AIW-1:0]          ifm_addr_q, row_q, col_q;
  logic [WCW-1:0]          w_cnt_q;
  logic [PW-1:0]           push_q;
  logic                    hold_w, wm_fire, ifm_fire;

`ifdef IFM_STREAM_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // A pending read is only issued (and its address consumed) when not held.
  assign wm_fire  = wm_rd_q & ~hold_w;
  assign ifm_fire = ifm_rd_q & ~hold_w;

  assign wm_enable_read  = wm_fire;
  assign ifm_enable_read = ifm_fire;
  assign wm_address      = wm_addr_q;
  assign ifm_address     = ifm_addr_q;
  assign wm_fifo_enable  = wm_fifo_en_q;
  assign fifo_enable     = fifo_en_q;
  assign unit_data_in    = fifo_en_q ? ifm_data_in : '0;
  assign conv_enable     = conv_q;
  assign busy            = busy_q;
  assign done            = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wm_rd_q      <= 1'b0;
      ifm_rd_q     <= 1'b0;
      wm_fifo_en_q <= 1'b0;
      fifo_en_q    <= 1'b0;
      conv_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drain_q      <= 1'b0;
      wm_addr_q    <= '0;
      ifm_addr_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      w_cnt_q      <= '0;
      push_q       <= '0;
    end else begin
      wm_fifo_en_q <= wm_fire;
      fifo_en_q    <= ifm_fire;
      conv_q       <= 1'b0;

      // (row_q, col_q) is the position of the pixel being pushed this cycle.
      if (fifo_en_q) begin
        conv_q <= (row_q >= K_EDGE) && (col_q >= K_EDGE) && (push_q >= P_MIN);
        push_q <= push_q + PW'(1);
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + AIW'(1);
        end else begin
          col_q <= col_q + AIW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LOAD_W;
            busy_q    <= 1'b1;
            wm_rd_q   <= 1'b1;
            wm_addr_q <= wm_base_address;
            w_cnt_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            push_q    <= '0;
          end
        end
        LOAD_W: begin
          if (wm_fire) begin
            if (w_cnt_q == W_LAST) begin
              state_q    <= STREAM;
              wm_rd_q    <= 1'b0;
              ifm_rd_q   <= 1'b1;
              ifm_addr_q <= '0;
            end else begin
              w_cnt_q   <= w_cnt_q + WCW'(1);
              wm_addr_q <= wm_addr_q + ADDRESS_BITS'(1);
            end
          end
        end
        STREAM: begin
          if (ifm_fire) begin
            if (ifm_addr_q == IFM_LAST) begin
              state_q  <= DRAIN;
              ifm_rd_q <= 1'b0;
              drain_q  <= 1'b0;
            end else begin
              ifm_addr_q <= ifm_addr_q + AIW'(1);
            end
          end
        end
        DRAIN: begin
          // One cycle for the last push, one for its window strobe.
          if (drain_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          done_q     <= 1'b0;
          wm_addr_q  <= '0;
          ifm_addr_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_stream_ctrl.sv
// Directed bench for ifm_stream_ctrl: per-cycle trace capture, key-cycle vector table, pass-level counts.
module tb_ifm_stream_ctrl;
  localparam int DW = 32;
  localparam int AB = 18;
  localparam int IS = 32;
  localparam int KS = 5;
  localparam int AI = 10;
  localparam logic [AB-1:0] B = 18'h3FFF8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AB-1:0] wm_base_address;
  logic [DW-1:0] ifm_data_in = '0;
  logic          ifm_enable_read, wm_enable_read, wm_fifo_enable;
  logic [AI-1:0] ifm_address;
  logic [AB-1:0] wm_address;
  logic [DW-1:0] unit_data_in;
  logic          fifo_enable, conv_enable, busy, done;
`ifdef IFM_STREAM_HOLD_EN
  logic          hold = 1'b0;
`endif

  ifm_stream_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .IFM_SIZE(IS), .KERNAL_SIZE(KS)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef IFM_STREAM_HOLD_EN
    .hold(hold),
`endif
    .start(start),
    .wm_base_address(wm_base_address),
    .ifm_data_in(ifm_data_in),
    .ifm_enable_read(ifm_enable_read),
    .ifm_address(ifm_address),
    .wm_enable_read(wm_enable_read),
    .wm_address(wm_address),
    .wm_fifo_enable(wm_fifo_enable),
    .unit_data_in(unit_data_in),
    .fifo_enable(fifo_enable),
    .conv_enable(conv_enable),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // IFM memory: data equals address, one-cycle latency; garbage when not read.
  always @(posedge clk) ifm_data_in <= ifm_enable_read ? DW'(ifm_address) : 32'hDEADBEEF;

  typedef struct packed {
    logic          wm_en;
    logic [AB-1:0] wm_addr;
    logic          wm_fifo;
    logic          ifm_en;
    logic [AI-1:0] ifm_addr;
    logic          fifo;
    logic [DW-1:0] data;
    logic          conv;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  obs_t trace [0:2299];
  vec_t tbl [17];

  function automatic obs_t sample();
    obs_t o;
    o.wm_en = wm_enable_read;   o.wm_addr = wm_address;  o.wm_fifo = wm_fifo_enable;
    o.ifm_en = ifm_enable_read; o.ifm_addr = ifm_address; o.fifo = fifo_enable;
    o.data = unit_data_in;      o.conv = conv_enable;     o.busy = busy;  o.done = done;
    return o;
  endfunction

  function automatic obs_t mk(input logic we, input logic [AB-1:0] wa, input logic wf,
                              input logic ie, input logic [AI-1:0] ia, input logic ff,
                              input logic [DW-1:0] d, input logic cv, input logic bz, input logic dn);
    obs_t o;
    o.wm_en = we; o.wm_addr = wa; o.wm_fifo = wf; o.ifm_en = ie; o.ifm_addr = ia;
    o.fifo = ff; o.data = d; o.conv = cv; o.busy = bz; o.done = dn;
    return o;
  endfunction

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Addresses are only meaningful while their read strobe is expected high.
  task automatic chk_obs(input string nm, input obs_t act, input obs_t exp, input bit mask);
    obs_t a;
    a = act;
    if (mask && !exp.wm_en)  a.wm_addr  = exp.wm_addr;
    if (mask && !exp.ifm_en) a.ifm_addr = exp.ifm_addr;
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_cycles(input logic [AB-1:0] base, input int ncyc, input int start_len,
                            input int hold_lo, input int hold_hi, input int rst_cyc);
    @(posedge clk); #1;
    wm_base_address = base;
    for (int t = 0; t < ncyc; t++) begin
      start = (t < start_len);
      reset = (t == rst_cyc);
`ifdef IFM_STREAM_HOLD_EN
      hold = (t >= hold_lo) && (t <= hold_hi);
`else
      if (hold_lo > hold_hi) start = start;
`endif
      @(negedge clk);
      trace[t] = sample();
      @(posedge clk); #1;
    end
    start = 1'b0;
    reset = 1'b0;
`ifdef IFM_STREAM_HOLD_EN
    hold = 1'b0;
`endif
  endtask

  // Reference derived from geometry: conv at t iff push at t-1 was a pixel with row,col >= KS-1.
  task automatic analyze(input int lo, input int hi, output int n_conv, output int first_conv,
                         output int last_conv, output int done_cyc, output int n_done,
                         output int data_err, output int qual_err, output int n_push);
    int e, ppix;
    bit pv, q;
    n_conv = 0; first_conv = -1; last_conv = -1; done_cyc = -1; n_done = 0;
    data_err = 0; qual_err = 0; n_push = 0; e = 0; ppix = 0; pv = 0;
    for (int t = lo; t <= hi; t++) begin
      q = pv && (ppix / IS >= KS-1) && (ppix % IS >= KS-1);
      if (trace[t].conv) begin
        n_conv++;
        if (first_conv < 0) first_conv = t;
        last_conv = t;
      end
      if (trace[t].conv != q) qual_err++;
      if (trace[t].done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = t;
      end
      if (trace[t].fifo) begin
        if (trace[t].data != DW'(e)) data_err++;
        pv = 1; ppix = e; e++; n_push++;
      end else begin
        if (trace[t].data != '0) data_err++;
        pv = 0;
      end
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 17; i++)
      chk_obs($sformatf("%s_cyc%0d", tag, tbl[i].cyc), trace[tbl[i].cyc], tbl[i].exp, 1'b1);
  endtask

  initial begin
    int nc, fc, lc, dc, nd, de, qe, np, idle_err, first_wm;

    //            cyc       wm_en wm_addr  wfifo ifm_en ifm_addr fifo data conv busy done
    tbl[0]  = '{0,    mk(0, 18'h0,     0, 0, 10'd0,    0, 0,    0, 0, 0)};
    tbl[1]  = '{1,    mk(1, 18'h3FFF8, 0, 0, 10'd0,    0, 0,    0, 1, 0)};
    tbl[2]  = '{2,    mk(1, 18'h3FFF9, 1, 0, 10'd0,    0, 0,    0, 1, 0)};
    tbl[3]  = '{9,    mk(1, 18'h00000, 1, 0, 10'd0,    0, 0,    0, 1, 0)};
    tbl[4]  = '{25,   mk(1, 18'h00010, 1, 0, 10'd0,    0, 0,    0, 1, 0)};
    tbl[5]  = '{26,   mk(0, 18'h0,     1, 1, 10'd0,    0, 0,    0, 1, 0)};
    tbl[6]  = '{27,   mk(0, 18'h0,     0, 1, 10'd1,    1, 0,    0, 1, 0)};
    tbl[7]  = '{28,   mk(0, 18'h0,     0, 1, 10'd2,    1, 1,    0, 1, 0)};
    tbl[8]  = '{159,  mk(0, 18'h0,     0, 1, 10'd133,  1, 132,  0, 1, 0)};
    tbl[9]  = '{160,  mk(0, 18'h0,     0, 1, 10'd134,  1, 133,  1, 1, 0)};
    tbl[10] = '{187,  mk(0, 18'h0,     0, 1, 10'd161,  1, 160,  1, 1, 0)};
    tbl[11] = '{188,  mk(0, 18'h0,     0, 1, 10'd162,  1, 161,  0, 1, 0)};
    tbl[12] = '{1049, mk(0, 18'h0,     0, 1, 10'd1023, 1, 1022, 1, 1, 0)};
    tbl[13] = '{1050, mk(0, 18'h0,     0, 0, 10'd0,    1, 1023, 1, 1, 0)};
    tbl[14] = '{1051, mk(0, 18'h0,     0, 0, 10'd0,    0, 0,    1, 1, 0)};
    tbl[15] = '{1052, mk(0, 18'h0,     0, 0, 10'd0,    0, 0,    0, 0, 1)};
    tbl[16] = '{1053, mk(0, 18'h0,     0, 0, 10'd0,    0, 0,    0, 0, 0)};

    reset = 1'b1; start = 1'b0; wm_base_address = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_obs("reset_state", sample(), '0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single pass, start pulse in cycle 0.
    run_cycles(B, 1070, 1, -1, -2, -1);
    check_table("p1");
    analyze(0, 1069, nc, fc, lc, dc, nd, de, qe, np);
    chk_int("p1_conv_count", nc, 784);
    chk_int("p1_first_conv", fc, 160);
    chk_int("p1_last_conv", lc, 1051);
    chk_int("p1_done_cyc", dc, 1052);
    chk_int("p1_done_count", nd, 1);
    chk_int("p1_data_err", de, 0);
    chk_int("p1_qual_err", qe, 0);
    chk_int("p1_push_count", np, 1024);

    // Reset in cycle 500 aborts the pass without a done pulse.
    run_cycles(B, 700, 1, -1, -2, 500);
    chk_int("rst_busy_before", int'(trace[500].busy), 1);
    chk_obs("rst_after", trace[501], '0, 1'b0);
    idle_err = 0;
    for (int t = 501; t < 700; t++)
      if (trace[t] !== '0) idle_err++;
    chk_int("rst_stays_idle", idle_err, 0);
    analyze(0, 699, nc, fc, lc, dc, nd, de, qe, np);
    chk_int("rst_no_done", nd, 0);

    run_cycles(B, 1070, 1, -1, -2, -1);
    check_table("p2");
    analyze(0, 1069, nc, fc, lc, dc, nd, de, qe, np);
    chk_int("p2_conv_count", nc, 784);
    chk_int("p2_qual_err", qe, 0);
    chk_int("p2_data_err", de, 0);

    // start held high: DONE cycle ignores it, next pass begins from IDLE at 1053.
    run_cycles(B, 2200, 2000, -1, -2, -1);
    analyze(0, 1052, nc, fc, lc, dc, nd, de, qe, np);
    chk_int("b2b_pass1_done", dc, 1052);
    chk_int("b2b_pass1_conv", nc, 784);
    first_wm = -1;
    for (int t = 1053; t < 2200; t++)
      if (first_wm < 0 && trace[t].wm_en) first_wm = t;
    chk_int("b2b_pass2_first_wm", first_wm, 1054);
    chk_int("b2b_pass2_first_addr", int'(trace[1054].wm_addr), int'(B));
    analyze(1053, 2199, nc, fc, lc, dc, nd, de, qe, np);
    chk_int("b2b_pass2_done", dc, 2105);
    chk_int("b2b_pass2_done_count", nd, 1);
    chk_int("b2b_pass2_conv", nc, 784);
    chk_int("b2b_pass2_qual_err", qe, 0);

`ifdef IFM_STREAM_HOLD_EN
    run_cycles(B, 1080, 1, 300, 309, -1);
    idle_err = 0;
    for (int t = 301; t <= 310; t++)
      if (trace[t].fifo) idle_err++;
    chk_int("hold_fifo_low", idle_err, 0);
    chk_int("hold_fifo_300", int'(trace[300].fifo), 1);
    chk_int("hold_fifo_311", int'(trace[311].fifo), 1);
    analyze(0, 1079, nc, fc, lc, dc, nd, de, qe, np);
    chk_int("hold_conv_count", nc, 784);
    chk_int("hold_done_cyc", dc, 1062);
    chk_int("hold_data_err", de, 0);
    chk_int("hold_qual_err", qe, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
